roi_crop_stride: RTL and testbench

//  Streaming region-of-interest crop with power-of-two decimation for raster pixel streams.

---
 rtl/roi_crop_pkg.sv | 67 ++++++
 rtl/roi_out_reg.sv | 39 +++
 rtl/roi_crop_stride.sv | 137 +++++++++++++
 tb/tb_roi_crop_stride.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_crop_pkg.sv
// Shared widths, shadow-configuration record and window-clipping helpers
// for the ROI crop/decimation block.
package roi_crop_pkg;

    localparam int MAX_COLS        = 1024;
    localparam int MAX_ROWS        = 1024;
    localparam int MAX_STRIDE_LOG2 = 3;

    localparam int CW = $clog2(MAX_COLS) + 1;
    localparam int RW = $clog2(MAX_ROWS) + 1;
    localparam int SW = $clog2(MAX_STRIDE_LOG2 + 1);

    // Per-frame configuration, including the derived clip ends and kept-column count.
    typedef struct packed {
        logic [CW-1:0] in_cols;
        logic [RW-1:0] in_rows;
        logic [CW-1:0] x1;
        logic [RW-1:0] y1;
        logic [CW:0]   xe;
        logic [RW:0]   ye;
        logic [SW-1:0] sx;
        logic [SW-1:0] sy;
        logic [CW-1:0] kcols;
    } cfg_t;

    // Exclusive right edge of the window, clipped to the frame width.
    function automatic logic [CW:0] clip_end_x(input logic [CW-1:0] start,
                                               input logic [CW-1:0] size,
                                               input logic [CW-1:0] limit);
        logic [CW:0] sum;
        sum = {1'b0, start} + {1'b0, size};
        if (sum > {1'b0, limit}) begin
            return {1'b0, limit};
        end else begin
            return sum;
        end
    endfunction

    // Exclusive bottom edge of the window, clipped to the frame height.
    function automatic logic [RW:0] clip_end_y(input logic [RW-1:0] start,
                                               input logic [RW-1:0] size,
                                               input logic [RW-1:0] limit);
        logic [RW:0] sum;
        sum = {1'b0, start} + {1'b0, size};
        if (sum > {1'b0, limit}) begin
            return {1'b0, limit};
        end else begin
            return sum;
        end
    endfunction

    // Number of columns kept per output row: ceil((xe - x1) / 2**sx), zero when empty.
    function automatic logic [CW-1:0] kept_cols(input logic [CW-1:0] x1,
                                                input logic [CW:0]   xe,
                                                input logic [SW-1:0] sx);
        logic [CW:0] span;
        logic [CW:0] rounded;
        if (xe <= {1'b0, x1}) begin
            return '0;
        end else begin
            span    = xe - {1'b0, x1};
            rounded = span + (((CW+1)'(1) << sx) - (CW+1)'(1));
            return CW'(rounded >> sx);
        end
    endfunction

endpackage

// File: rtl/roi_out_reg.sv
// One-entry valid/ready output register carrying pixel data plus sof/eol.
// Accepts a new beat in the same cycle the held one is consumed.
module roi_out_reg #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic         load_sof,
    input  logic         load_eol,
    output logic         load_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_sof,
    output logic         out_eol,
    input  logic         out_ready
);

    assign load_ready = !out_valid || out_ready;

    // Load on a new beat, drain when consumed, otherwise hold the payload steady.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (load_valid && load_ready) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_sof   <= load_sof;
            out_eol   <= load_eol;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/roi_crop_stride.sv
// Streaming region-of-interest crop with power-of-two decimation.
// Raster counters walk the input frame; a per-frame shadow configuration
// decides which pixels are kept and where the sof/eol markers fall.
module roi_crop_stride
    import roi_crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CW-1:0]              cfg_in_cols,
    input  logic [RW-1:0]              cfg_in_rows,
    input  logic [CW-1:0]              cfg_x1,
    input  logic [RW-1:0]              cfg_y1,
    input  logic [CW-1:0]              cfg_w,
    input  logic [RW-1:0]              cfg_h,
    input  logic [SW-1:0]              cfg_sx_log2,
    input  logic [SW-1:0]              cfg_sy_log2,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       frame_done
);

    cfg_t          cfg_r;
    cfg_t          cfg_next_s;
    logic [CW-1:0] x_r;
    logic [RW-1:0] y_r;
    logic [CW-1:0] ocol_r;
    logic          sof_pending_r;
    logic          frame_done_r;

    logic [CW-1:0] x_off_s;
    logic [CW-1:0] mask_x_s;
    logic [RW-1:0] y_off_s;
    logic [RW-1:0] mask_y_s;
    logic          in_x_s;
    logic          in_y_s;
    logic          keep_s;
    logic          load_ready_s;
    logic          accept_s;
    logic          load_s;
    logic          last_x_s;
    logic          last_y_s;
    logic          frame_end_s;
    logic          eol_s;

    // Candidate shadow configuration with clip ends and kept-column count derived up front.
    always_comb begin
        cfg_next_s         = '0;
        cfg_next_s.in_cols = cfg_in_cols;
        cfg_next_s.in_rows = cfg_in_rows;
        cfg_next_s.x1      = cfg_x1;
        cfg_next_s.y1      = cfg_y1;
        cfg_next_s.xe      = clip_end_x(cfg_x1, cfg_w, cfg_in_cols);
        cfg_next_s.ye      = clip_end_y(cfg_y1, cfg_h, cfg_in_rows);
        cfg_next_s.sx      = cfg_sx_log2;
        cfg_next_s.sy      = cfg_sy_log2;
        cfg_next_s.kcols   = kept_cols(cfg_x1, cfg_next_s.xe, cfg_sx_log2);
    end

    // Keep decision uses only registered position and shadow config, never in_valid.
    assign x_off_s  = x_r - cfg_r.x1;
    assign y_off_s  = y_r - cfg_r.y1;
    assign mask_x_s = (CW'(1) << cfg_r.sx) - CW'(1);
    assign mask_y_s = (RW'(1) << cfg_r.sy) - RW'(1);
    assign in_x_s   = ({1'b0, x_r} >= {1'b0, cfg_r.x1}) && ({1'b0, x_r} < cfg_r.xe)
                      && ((x_off_s & mask_x_s) == '0);
    assign in_y_s   = ({1'b0, y_r} >= {1'b0, cfg_r.y1}) && ({1'b0, y_r} < cfg_r.ye)
                      && ((y_off_s & mask_y_s) == '0);
    assign keep_s   = in_x_s && in_y_s;

    // Dropped pixels never wait on the output register.
    assign in_ready    = !keep_s || load_ready_s;
    assign accept_s    = in_valid && in_ready;
    assign load_s      = accept_s && keep_s;
    assign last_x_s    = (x_r == cfg_r.in_cols - CW'(1));
    assign last_y_s    = (y_r == cfg_r.in_rows - RW'(1));
    assign frame_end_s = accept_s && last_x_s && last_y_s;
    assign eol_s       = (ocol_r == cfg_r.kcols - CW'(1));
    assign frame_done  = frame_done_r;

    // Raster position, per-row kept count, sof tracking and per-frame config latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r           <= '0;
            y_r           <= '0;
            ocol_r        <= '0;
            sof_pending_r <= 1'b1;
            frame_done_r  <= 1'b0;
            cfg_r         <= cfg_next_s;
        end else begin
            frame_done_r <= frame_end_s;
            if (accept_s) begin
                if (last_x_s) begin
                    x_r    <= '0;
                    ocol_r <= '0;
                    y_r    <= last_y_s ? '0 : y_r + RW'(1);
                end else begin
                    x_r <= x_r + CW'(1);
                    if (load_s) begin
                        ocol_r <= ocol_r + CW'(1);
                    end
                end
            end
            if (frame_end_s) begin
                cfg_r         <= cfg_next_s;
                sof_pending_r <= 1'b1;
            end else if (load_s) begin
                sof_pending_r <= 1'b0;
            end
        end
    end

    roi_out_reg #(
        .W(PIXEL_BIT_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_s),
        .load_data  (pixel_in),
        .load_sof   (sof_pending_r),
        .load_eol   (eol_s),
        .load_ready (load_ready_s),
        .out_data   (pixel_out),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_ready  (out_ready)
    );

endmodule

// File: tb/tb_roi_crop_stride.sv
// Scoreboard bench for roi_crop_stride: a raster reference model pushes
// expected output beats as pixels are accepted; a monitor pops and compares.
module tb_roi_crop_stride;
    import roi_crop_pkg::*;

    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] cfg_in_cols, cfg_x1, cfg_w;
    logic [RW-1:0] cfg_in_rows, cfg_y1, cfg_h;
    logic [SW-1:0] cfg_sx_log2, cfg_sy_log2;
    logic [PW-1:0] pixel_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] pixel_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sof, out_eol, frame_done;

    typedef struct {
        int cols, rows, x1, y1, w, h, sx, sy;
    } tcfg_t;

    typedef struct packed {
        logic [PW-1:0] pix;
        logic          sof;
        logic          eol;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   discard = 0;
    int   rmode = 0;
    int   out_count = 0;
    int   gaps = 0;

    roi_crop_stride #(.PIXEL_BIT_WIDTH(PW)) dut (
        .clk(clk), .reset(reset),
        .cfg_in_cols(cfg_in_cols), .cfg_in_rows(cfg_in_rows),
        .cfg_x1(cfg_x1), .cfg_y1(cfg_y1), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_sx_log2(cfg_sx_log2), .cfg_sy_log2(cfg_sy_log2),
        .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive_cfg(input tcfg_t c);
        cfg_in_cols = CW'(c.cols);
        cfg_in_rows = RW'(c.rows);
        cfg_x1      = CW'(c.x1);
        cfg_y1      = RW'(c.y1);
        cfg_w       = CW'(c.w);
        cfg_h       = RW'(c.h);
        cfg_sx_log2 = SW'(c.sx);
        cfg_sy_log2 = SW'(c.sy);
    endtask

    function automatic tcfg_t mk(input int cols, rows, x1, y1, w, h, sx, sy);
        tcfg_t c;
        c.cols = cols; c.rows = rows; c.x1 = x1; c.y1 = y1;
        c.w = w; c.h = h; c.sx = sx; c.sy = sy;
        return c;
    endfunction

    function automatic tcfg_t rand_cfg();
        tcfg_t c;
        c.cols = $urandom_range(1, 12);
        c.rows = $urandom_range(1, 8);
        c.x1   = $urandom_range(0, c.cols + 1);
        c.y1   = $urandom_range(0, c.rows + 1);
        c.w    = $urandom_range(1, 8);
        c.h    = $urandom_range(1, 6);
        c.sx   = $urandom_range(0, 3);
        c.sy   = $urandom_range(0, 3);
        return c;
    endfunction

    // Downstream backpressure pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pop and compare on each handshake; check stalled outputs stay put.
    initial begin
        exp_t e;
        exp_t held;
        bit   hold_chk;
        hold_chk = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (discard != 0) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(pixel_out), int'(held.pix));
                    chk("hold_sof", int'(out_sof), int'(held.sof));
                    chk("hold_eol", int'(out_eol), int'(held.eol));
                end
                hold_chk = out_valid && !out_ready;
                held     = {pixel_out, out_sof, out_eol};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", int'(pixel_out), -1);
                    end else begin
                        e = q.pop_front();
                        chk("out_pixel", int'(pixel_out), int'(e.pix));
                        chk("out_sof", int'(out_sof), int'(e.sof));
                        chk("out_eol", int'(out_eol), int'(e.eol));
                        out_count++;
                    end
                end
            end
        end
    end

    // Send one frame under config c; nxt is driven mid-frame and takes effect next frame.
    task automatic run_frame(input tcfg_t c, input tcfg_t nxt, input int abort_at, input int exp_cnt);
        int            n, xe, ye, idx, base, waits, first;
        bit            accepted;
        logic [PW-1:0] pix[];
        bit            kept[];
        exp_t          ex[];
        n     = c.cols * c.rows;
        pix   = new[n];
        kept  = new[n];
        ex    = new[n];
        xe    = (c.x1 + c.w < c.cols) ? c.x1 + c.w : c.cols;
        ye    = (c.y1 + c.h < c.rows) ? c.y1 + c.h : c.rows;
        first = 1;
        for (int r = 0; r < c.rows; r++) begin
            for (int cc = 0; cc < c.cols; cc++) begin
                idx       = r * c.cols + cc;
                pix[idx]  = PW'($urandom);
                kept[idx] = (r >= c.y1) && (r < ye) && (cc >= c.x1) && (cc < xe)
                            && ((cc - c.x1) % (1 << c.sx) == 0) && ((r - c.y1) % (1 << c.sy) == 0);
                ex[idx]   = '0;
                if (kept[idx]) begin
                    ex[idx].pix = pix[idx];
                    ex[idx].sof = 1'(first);
                    ex[idx].eol = (cc + (1 << c.sx) >= xe);
                    first = 0;
                end
            end
        end
        base    = out_count;
        discard = (abort_at >= 0) ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            while (gaps != 0 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            pixel_in = pix[i];
            accepted = 1'b0;
            waits    = 0;
            while (!accepted) begin
                @(negedge clk);
                if (!kept[i]) chk("in_ready_drop", int'(in_ready), 1);
                if (in_ready) begin
                    accepted = 1'b1;
                end else begin
                    waits++;
                    if (waits > 200) begin
                        chk("in_ready_timeout", waits, 0);
                        in_valid = 1'b0;
                        return;
                    end
                    @(posedge clk);
                    #1;
                end
            end
            if (kept[i] && discard == 0) q.push_back(ex[i]);
            if (i == n / 2) drive_cfg(nxt);
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                chk("abort_out_valid", int'(out_valid), 0);
                chk("abort_frame_done", int'(frame_done), 0);
                reset    = 1'b0;
                in_valid = 1'b0;
                discard  = 0;
                return;
            end
            @(posedge clk);
            #1;
            chk("frame_done", int'(frame_done), (i == n - 1) ? 1 : 0);
        end
        in_valid = 1'b0;
        waits = 0;
        while (q.size() != 0 && waits < 500) begin
            @(posedge clk);
            waits++;
        end
        #1;
        chk("drain", q.size(), 0);
        if (exp_cnt >= 0) chk("frame_out_count", out_count - base, exp_cnt);
    endtask

    initial begin
        tcfg_t t1, t2, t4, t5b;
        tcfg_t rc[9];
        t1  = mk(8, 6, 2, 1, 4, 3, 0, 0);
        t2  = mk(8, 6, 2, 1, 4, 3, 1, 1);
        t4  = mk(8, 6, 6, 1, 4, 3, 0, 0);
        t5b = mk(8, 6, 3, 1, 4, 3, 0, 0);
        for (int k = 0; k < 9; k++) rc[k] = rand_cfg();

        drive_cfg(t1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_pixel_out", int'(pixel_out), 0);
        chk("reset_sof", int'(out_sof), 0);
        chk("reset_eol", int'(out_eol), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;

        rmode = 0;
        run_frame(t1, t2, -1, 12);
        run_frame(t2, t1, -1, 4);
        rmode = 1;
        run_frame(t1, t4, -1, 12);
        rmode = 0;
        run_frame(t4, t1, -1, 6);
        run_frame(t1, t5b, -1, 12);
        run_frame(t5b, t1, -1, 12);
        run_frame(t1, t1, 19, -1);
        run_frame(t1, rc[0], -1, 12);

        gaps  = 1;
        rmode = 2;
        for (int k = 0; k < 8; k++) run_frame(rc[k], rc[k + 1], -1, -1);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if something wedges beyond every per-wait bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
